// File: rtl/timer_arbiter_pkg.sv
// Shared types, default sizes and the round-robin pick helper for the delay-timer arbiter.
package timer_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ta_state_t;

  localparam int TA_WIDTH = 4;
  localparam int TA_NREQ  = 4;

  // First set bit of req searching upward from ptr+1, wrapping modulo nreq (nreq <= 8).
  function automatic int rr_pick(input int ptr, input logic [7:0] req, input int nreq);
    int  pick;
    bit  found;
    pick  = 0;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      int idx;
      idx = (ptr + i) % nreq;
      if (!found && (i <= nreq) && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/load_down_counter.sv
// Loadable down-counter that saturates at zero; clear wins over load, load wins over decrement.
module load_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt,
  output logic             is_one
);

  logic [WIDTH-1:0] cnt_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - WIDTH'(1);
    end
  end

  assign cnt    = cnt_reg;
  assign is_one = (cnt_reg == WIDTH'(1));

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin arbiter granting one shared down-counter; pulses done to the winner at terminal count.
module timer_arbiter
  import timer_arbiter_pkg::*;
#(
  parameter int WIDTH = TA_WIDTH,
  parameter int NREQ  = TA_NREQ
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] len,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [WIDTH-1:0]      cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  ta_state_t        state_reg, state_next;
  logic [NREQ-1:0]  gnt_reg, gnt_next;
  logic [NREQ-1:0]  done_reg, done_next;
  logic [PW-1:0]    ptr_reg, ptr_next;
  logic [PW-1:0]    win;
  logic [WIDTH-1:0] len_sel;
  logic [WIDTH-1:0] load_val;
  logic             load, dec, clr, is_one;

  assign win      = PW'(rr_pick(int'(ptr_reg), 8'(req), NREQ));
  assign len_sel  = len[win*WIDTH +: WIDTH];
  // A zero length still costs one tick so done is always a distinct cycle.
  assign load_val = (len_sel == '0) ? WIDTH'(1) : len_sel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      done_reg  <= '0;
      ptr_reg   <= PW'(NREQ - 1);
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      done_reg  <= done_next;
      ptr_reg   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    done_next  = '0;
    ptr_next   = ptr_reg;
    load       = 1'b0;
    dec        = 1'b0;
    clr        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          gnt_next   = NREQ'(1) << win;
          ptr_next   = win;
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        // Abort outranks terminal count when the winner drops its request.
        if ((req & gnt_reg) == '0) begin
          gnt_next   = '0;
          clr        = 1'b1;
          state_next = IDLE;
        end else begin
          dec = 1'b1;
          if (is_one) begin
            done_next  = gnt_reg;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        gnt_next   = '0;
        state_next = IDLE;
      end
      default: begin
        gnt_next   = '0;
        clr        = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  load_down_counter #(.WIDTH(WIDTH)) u_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .load_val (load_val),
    .dec      (dec),
    .clr      (clr),
    .cnt      (cnt),
    .is_one   (is_one)
  );

  assign gnt  = gnt_reg;
  assign done = done_reg;
  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed self-checking bench for timer_arbiter with hand-computed per-cycle expectations.
module tb_timer_arbiter;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req;
  logic [15:0] len;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic [3:0]  cnt;

  int errors = 0;
  int checks = 0;

  timer_arbiter #(.WIDTH(4), .NREQ(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .len     (len),
    .gnt     (gnt),
    .done    (done),
    .busy    (busy),
    .cnt     (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] e_gnt, input logic [3:0] e_done,
                            input logic [3:0] e_cnt, input logic e_busy);
    chk({tag, ".gnt"},  32'(gnt),  32'(e_gnt));
    chk({tag, ".done"}, 32'(done), 32'(e_done));
    chk({tag, ".cnt"},  32'(cnt),  32'(e_cnt));
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
  endtask

  initial begin
    int rr_seq [5] = '{0, 1, 2, 3, 0};

    // Reset held with all requests asserted.
    reset_n = 1'b0;
    req     = 4'b1111;
    len     = '0;
    repeat (2) tick();
    expect_out("rst_hold", 4'b0000, 4'b0000, 4'd0, 1'b0);
    req     = 4'b0000;
    reset_n = 1'b1;
    repeat (4) tick();
    expect_out("rst_idle", 4'b0000, 4'b0000, 4'd0, 1'b0);
    $display("tb: reset phase complete");

    // Single request, len0 = 5.
    len = {4'd0, 4'd0, 4'd0, 4'd5};
    req = 4'b0001;
    tick();
    expect_out("single_grant", 4'b0001, 4'b0000, 4'd5, 1'b1);
    for (int k = 4; k >= 1; k--) begin
      tick();
      expect_out("single_run", 4'b0001, 4'b0000, 4'(k), 1'b1);
    end
    tick();
    expect_out("single_done", 4'b0001, 4'b0001, 4'd0, 1'b1);
    req = 4'b0000;
    tick();
    expect_out("single_idle", 4'b0000, 4'b0000, 4'd0, 1'b0);
    $display("tb: single request complete");

    // Round robin from a fresh pointer, all lengths 2.
    pulse_reset();
    len = {4'd2, 4'd2, 4'd2, 4'd2};
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      tick();
      expect_out("rr_grant", 4'(1 << rr_seq[n]), 4'b0000, 4'd2, 1'b1);
      tick();
      expect_out("rr_run", 4'(1 << rr_seq[n]), 4'b0000, 4'd1, 1'b1);
      tick();
      expect_out("rr_done", 4'(1 << rr_seq[n]), 4'(1 << rr_seq[n]), 4'd0, 1'b1);
      if (n == 4) req = 4'b0000;
      tick();
      expect_out("rr_gap", 4'b0000, 4'b0000, 4'd0, 1'b0);
      $display("tb: round robin grant %0d to requester %0d", n, rr_seq[n]);
    end

    // len0 = 0 behaves as len 1.
    len = {4'd2, 4'd2, 4'd2, 4'd0};
    req = 4'b0001;
    tick();
    expect_out("len0_grant", 4'b0001, 4'b0000, 4'd1, 1'b1);
    tick();
    expect_out("len0_done", 4'b0001, 4'b0001, 4'd0, 1'b1);
    req = 4'b0000;
    tick();
    expect_out("len0_idle", 4'b0000, 4'b0000, 4'd0, 1'b0);
    $display("tb: zero length complete");

    // len0 = 15, no wrap.
    len = {4'd2, 4'd2, 4'd2, 4'd15};
    req = 4'b0001;
    tick();
    expect_out("len15_grant", 4'b0001, 4'b0000, 4'd15, 1'b1);
    for (int k = 14; k >= 1; k--) begin
      tick();
      expect_out("len15_run", 4'b0001, 4'b0000, 4'(k), 1'b1);
    end
    tick();
    expect_out("len15_done", 4'b0001, 4'b0001, 4'd0, 1'b1);
    req = 4'b0000;
    tick();
    expect_out("len15_idle", 4'b0000, 4'b0000, 4'd0, 1'b0);
    $display("tb: max length complete");

    // Abort of requester 1 at cnt 3, then requester 2 is served.
    len = {4'd2, 4'd3, 4'd6, 4'd2};
    req = 4'b0110;
    tick();
    expect_out("abort_grant", 4'b0010, 4'b0000, 4'd6, 1'b1);
    for (int k = 5; k >= 3; k--) begin
      tick();
      expect_out("abort_run", 4'b0010, 4'b0000, 4'(k), 1'b1);
    end
    req = 4'b0100;
    tick();
    expect_out("abort_idle", 4'b0000, 4'b0000, 4'd0, 1'b0);
    tick();
    expect_out("abort_next", 4'b0100, 4'b0000, 4'd3, 1'b1);
    tick();
    expect_out("abort_next_run", 4'b0100, 4'b0000, 4'd2, 1'b1);
    tick();
    expect_out("abort_next_run", 4'b0100, 4'b0000, 4'd1, 1'b1);
    tick();
    expect_out("abort_next_done", 4'b0100, 4'b0100, 4'd0, 1'b1);
    $display("tb: abort mid-count complete");

    // Abort exactly at cnt 1 suppresses done.
    len = {4'd2, 4'd3, 4'd2, 4'd2};
    req = 4'b0010;
    tick();
    expect_out("abort1_gap", 4'b0000, 4'b0000, 4'd0, 1'b0);
    tick();
    expect_out("abort1_grant", 4'b0010, 4'b0000, 4'd2, 1'b1);
    tick();
    expect_out("abort1_run", 4'b0010, 4'b0000, 4'd1, 1'b1);
    req = 4'b0000;
    tick();
    expect_out("abort1_idle", 4'b0000, 4'b0000, 4'd0, 1'b0);
    tick();
    expect_out("abort1_quiet", 4'b0000, 4'b0000, 4'd0, 1'b0);
    $display("tb: abort at terminal count complete");

    // Asynchronous reset while cnt = 4; pointer must restart at requester 0.
    len = {4'd2, 4'd2, 4'd2, 4'd6};
    req = 4'b0001;
    tick();
    expect_out("mrst_grant", 4'b0001, 4'b0000, 4'd6, 1'b1);
    tick();
    tick();
    expect_out("mrst_run", 4'b0001, 4'b0000, 4'd4, 1'b1);
    req     = 4'b1001;
    reset_n = 1'b0;
    #2;
    expect_out("mrst_async", 4'b0000, 4'b0000, 4'd0, 1'b0);
    reset_n = 1'b1;
    tick();
    expect_out("mrst_regrant", 4'b0001, 4'b0000, 4'd6, 1'b1);
    req = 4'b0000;
    tick();
    expect_out("mrst_abort", 4'b0000, 4'b0000, 4'd0, 1'b0);
    $display("tb: mid-run reset complete");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_arbiter.md
# timer_arbiter

Shared delay-timer controller. Up to NREQ requesters each ask for a delay of `len` clock ticks; the block grants a single down-counter to one requester at a time in round-robin order, sequences the count, and pulses `done` back to the winner. It sits between the requesting control blocks and the counter datapath, which is the only timing resource they share.

## Interface
- `WIDTH`, 4: counter and per-requester length width.
- `NREQ`, 4: number of requesters, 2..8.
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `req` input NREQ: request per requester; must be held until `done` or dropped to abort.
- `len` input NREQ*WIDTH: delay for requester i in bits [i*WIDTH +: WIDTH]; sampled only at grant.
- `gnt` output NREQ: one-hot grant, registered.
- `done` output NREQ: one-cycle completion pulse to the granted requester.
- `busy` output 1: high whenever state is not IDLE.
- `cnt` output WIDTH: current counter value.

## Operation
- States: IDLE, RUN, DONE. Reset gives state IDLE, `gnt`=0, `done`=0, `cnt`=0, `busy`=0, pointer `ptr`=NREQ-1, so requester 0 wins first.
- IDLE: on an edge with any `req` set, pick the winner `w` as the first set bit searching from `ptr`+1 upward, modulo NREQ.
  - `gnt[w]` is set, `ptr` becomes w, and `cnt` loads max(len_w,1).
  - State goes to RUN.
- RUN: each edge decrements `cnt`. On the edge where `cnt`==1: `cnt` becomes 0, `done[w]` becomes 1, and state goes to DONE.
- DONE: lasts exactly one cycle. On the next edge `gnt` and `done` clear and state goes to IDLE. `req` is ignored during DONE.
- Abort: in RUN, if `req[w]` is 0 at an edge, the block goes to IDLE with `gnt`=0 and `cnt`=0, and no `done` is issued.
  - Abort takes priority over terminal count on the same edge.
  - `ptr` keeps w.
- `len`=0 is treated as 1. Arithmetic is unsigned WIDTH bits. `cnt` never decrements below 0 and never wraps.
- A requester that keeps `req` high after `done` is re-eligible under normal round-robin order.
- Non-granted `req` changes have no effect while busy.
- Reset asserted mid-operation clears all state and outputs immediately, without waiting for a clock. No pending `done` is delivered.

## Timing
- Grant latency: one edge from `req` being seen in IDLE.
- For length L (after the 0→1 clamp):
  - `gnt` is high for L+1 cycles.
  - `cnt` shows L, L-1, …, 1 during RUN, then 0 during DONE.
  - `done` is high during the final `gnt` cycle.
- Minimum spacing between grants: one IDLE cycle. The next grant can be registered on the edge that ends that IDLE cycle.
- All outputs come from registers. `busy` is decoded from the state register only.

## Structure
- Package `timer_arbiter_pkg` holds:
  - the state enum `ta_state_t` (IDLE, RUN, DONE);
  - the default WIDTH and NREQ constants;
  - a round-robin pick function (`ptr`, `req`) → index.
- Sub-module `load_down_counter` (WIDTH): inputs `load`, `load_val`, `dec`, `clr`; outputs `cnt` and `is_one`. Same async active-low reset.
- Top level contains the FSM, the pointer, and the `len` slice mux.

## Test plan
- Reset: hold `reset_n`=0 with `req`=1111. Required: `gnt`, `done`, `cnt` and `busy` all 0. After release with `req`=0000, the block stays IDLE indefinitely.
- Single request: `req`=0001, len0=5. Required:
  - `gnt`=0001 after the first edge;
  - `cnt` 5,4,3,2,1 on successive cycles;
  - `done`=0001 for one cycle with `cnt`=0;
  - `gnt`=0000 on the following cycle.
- Round robin: `req`=1111 held, all len=2. Required: grant order 0,1,2,3,0. Each grant lasts 3 cycles, separated by 1 idle cycle.
- Length boundaries:
  - len0=0: `done` on the second cycle after grant, identical to len=1.
  - len0=15: 15 RUN cycles, then `done`, with no wrap of `cnt`.
- Abort: `req`=0110, requester 1 granted with len=6, `req[1]` dropped when `cnt`=3. Required: the next edge gives IDLE, `gnt`=0 and no `done`; the following grant goes to requester 2. Dropping `req[1]` exactly at `cnt`=1 also gives no `done`.
- Reset mid-run: `reset_n` pulsed low while `cnt`=4. Required: `gnt`, `done` and `cnt` go to 0 asynchronously. After release with `req`=1001, requester 0 is granted first.
